uart: RTL and testbench

Full-duplex 8N1 UART transceiver with an independent transmitter and receiver. It serializes a parallel word onto `serial_out` and deserializes `serial_in` into `received_data`, flagging good and bad frames. It sits between on-chip logic and an external serial line; the block-level bench connects `serial_out` back to `serial_in` in loopback.

---
 rtl/uart.sv | 221 ++++++++++++++++++++++
 tb/tb_uart.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock.
// Both directions are two-process FSMs whose registered outputs come straight from flops.
module uart #(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int CLKS_PER_BIT     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [INPUT_DATA_WIDTH-1:0] i_data,
   output logic                        o_busy,
   output logic                        serial_out,
   input  logic                        serial_in,
   output logic [INPUT_DATA_WIDTH-1:0] received_data,
   output logic                        data_is_valid,
   output logic                        rx_error
);

   localparam int W  = INPUT_DATA_WIDTH;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (W > 1) ? $clog2(W) : 1;

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(W - 1);

   // ---------------------------------------------------------------- transmitter
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t       tx_state, tx_state_nx;
   logic [CW-1:0]   tx_cnt, tx_cnt_nx;
   logic [IW-1:0]   tx_idx, tx_idx_nx;
   logic [W-1:0]    tx_shift, tx_shift_nx;
   logic            busy_nx, line_nx;

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      tx_idx_nx   = tx_idx;
      tx_shift_nx = tx_shift;
      busy_nx     = o_busy;
      line_nx     = serial_out;
      case (tx_state)
         TX_IDLE: begin
            if (enable) begin
               tx_state_nx = TX_START;
               tx_cnt_nx   = '0;
               tx_idx_nx   = '0;
               tx_shift_nx = i_data;
               busy_nx     = 1'b1;
               line_nx     = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt == BIT_LAST) begin
               tx_state_nx = TX_DATA;
               tx_cnt_nx   = '0;
               line_nx     = tx_shift[0];
               tx_shift_nx = tx_shift >> 1;
            end else begin
               tx_cnt_nx = tx_cnt + CW'(1);
            end
         end
         TX_DATA: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_nx = '0;
               if (tx_idx == IDX_LAST) begin
                  tx_state_nx = TX_STOP;
                  line_nx     = 1'b1;
               end else begin
                  tx_idx_nx   = tx_idx + IW'(1);
                  line_nx     = tx_shift[0];
                  tx_shift_nx = tx_shift >> 1;
               end
            end else begin
               tx_cnt_nx = tx_cnt + CW'(1);
            end
         end
         TX_STOP: begin
            if (tx_cnt == BIT_LAST) begin
               tx_state_nx = TX_IDLE;
               tx_cnt_nx   = '0;
               busy_nx     = 1'b0;
               line_nx     = 1'b1;
            end else begin
               tx_cnt_nx = tx_cnt + CW'(1);
            end
         end
         default: begin
            tx_state_nx = TX_IDLE;
            busy_nx     = 1'b0;
            line_nx     = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state   <= TX_IDLE;
         tx_cnt     <= '0;
         tx_idx     <= '0;
         o_busy     <= 1'b0;
         serial_out <= 1'b1;
      end else begin
         tx_state   <= tx_state_nx;
         tx_cnt     <= tx_cnt_nx;
         tx_idx     <= tx_idx_nx;
         o_busy     <= busy_nx;
         serial_out <= line_nx;
      end
   end

   // NOTE: shift registers are pure datapath, always loaded before use, so they carry no reset.
   always_ff @(posedge clk) tx_shift <= tx_shift_nx;

   // ---------------------------------------------------------------- receiver
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

   rx_state_t       rx_state, rx_state_nx;
   logic [CW-1:0]   rx_cnt, rx_cnt_nx;
   logic [IW-1:0]   rx_idx, rx_idx_nx;
   logic [W-1:0]    rx_shift, rx_shift_nx;
   logic [W-1:0]    data_nx;
   logic            valid_nx, error_nx;
   logic            rx_meta, rx_sync;

   // Two-flop synchronizer; held at the idle level through reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= serial_in;
         rx_sync <= rx_meta;
      end
   end

   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = rx_cnt;
      rx_idx_nx   = rx_idx;
      rx_shift_nx = rx_shift;
      data_nx     = received_data;
      valid_nx    = 1'b0;
      error_nx    = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_sync) begin
               rx_state_nx = RX_START;
               rx_cnt_nx   = '0;
            end
         end
         RX_START: begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_nx   = '0;
               rx_idx_nx   = '0;
               rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_nx = rx_cnt + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nx          = '0;
               rx_shift_nx        = rx_shift >> 1;
               rx_shift_nx[W-1]   = rx_sync;
               if (rx_idx == IDX_LAST) begin
                  rx_state_nx = RX_STOP;
               end else begin
                  rx_idx_nx = rx_idx + IW'(1);
               end
            end else begin
               rx_cnt_nx = rx_cnt + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nx = '0;
               if (rx_sync) begin
                  data_nx     = rx_shift;
                  valid_nx    = 1'b1;
                  rx_state_nx = RX_IDLE;
               end else begin
                  error_nx    = 1'b1;
                  rx_state_nx = RX_WAIT_IDLE;
               end
            end else begin
               rx_cnt_nx = rx_cnt + CW'(1);
            end
         end
         RX_WAIT_IDLE: begin
            if (rx_sync) rx_state_nx = RX_IDLE;
         end
         default: rx_state_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         rx_idx        <= '0;
         received_data <= '0;
         data_is_valid <= 1'b0;
         rx_error      <= 1'b0;
      end else begin
         rx_state      <= rx_state_nx;
         rx_cnt        <= rx_cnt_nx;
         rx_idx        <= rx_idx_nx;
         received_data <= data_nx;
         data_is_valid <= valid_nx;
         rx_error      <= error_nx;
      end
   end

   always_ff @(posedge clk) rx_shift <= rx_shift_nx;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: frame-level model of the line and expected RX pulses,
// one per-cycle compare process, plus directed tests with literal expectations.
module tb_uart;

   localparam int W     = 8;
   localparam int CPB   = 16;
   localparam int FRAME = (W + 2) * CPB;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic [W-1:0] i_data = '0;
   logic         o_busy, serial_out, serial_in;
   logic [W-1:0] received_data;
   logic         data_is_valid, rx_error;

   logic         ext_mode = 1'b0;
   logic         ext_line = 1'b1;
   assign serial_in = ext_mode ? ext_line : serial_out;

   uart #(.INPUT_DATA_WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .enable(enable), .i_data(i_data),
      .o_busy(o_busy), .serial_out(serial_out), .serial_in(serial_in),
      .received_data(received_data), .data_is_valid(data_is_valid), .rx_error(rx_error)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------ behavioural model
   typedef struct {
      bit           good;
      logic [W-1:0] data;
      int           earliest;
      int           latest;
   } exp_t;

   exp_t         q[$];
   bit           m_busy = 1'b0;
   int           m_t = 0;
   logic [W-1:0] m_word = '0;
   logic [W-1:0] m_rx_data = '0;

   // A frame whose start bit begins at cycle s produces its RX pulse within 4 cycles after mid-stop.
   function automatic void push_exp(input bit good, input logic [W-1:0] data, input int s);
      exp_t e;
      e.good     = good;
      e.data     = data;
      e.earliest = s + ((2 * W + 3) * CPB) / 2;
      e.latest   = e.earliest + 4;
      q.push_back(e);
   endfunction

   function automatic logic exp_line();
      int b;
      if (!m_busy) return 1'b1;
      b = m_t / CPB;
      if (b == 0) return 1'b0;
      if (b <= W) return m_word[b-1];
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_busy    = 1'b0;
         m_t       = 0;
         m_rx_data = '0;
         q.delete();
      end else if (m_busy) begin
         m_t++;
         if (m_t == FRAME) m_busy = 1'b0;
      end else if (enable) begin
         m_busy = 1'b1;
         m_t    = 0;
         m_word = i_data;
         if (!ext_mode) push_exp(1'b1, i_data, cyc);
      end
   end

   // ------------------------------------------------------------ compare process
   bit           run_cmp = 1'b0;
   logic [W-1:0] obs_valid[$];
   int           obs_err = 0;

   always @(negedge clk) begin
      if (run_cmp) begin
         check("serial_out", serial_out, exp_line());
         check("o_busy", o_busy, m_busy);
         if (data_is_valid) obs_valid.push_back(received_data);
         if (rx_error) obs_err++;
         if (q.size() == 0) begin
            check("rx_no_pulse", {data_is_valid, rx_error}, 2'b00);
         end else if (data_is_valid || rx_error || cyc >= q[0].latest) begin
            check("rx_pulse_kind", {data_is_valid, rx_error}, q[0].good ? 2'b10 : 2'b01);
            check("rx_pulse_early", cyc >= q[0].earliest, 1'b1);
            if (q[0].good) m_rx_data = q[0].data;
            void'(q.pop_front());
         end
         check("received_data", received_data, m_rx_data);
      end
   end

   // ------------------------------------------------------------ stimulus helpers
   // Raise enable in the first cycle o_busy is low; returns #1 after the accepting edge.
   task automatic send(input logic [W-1:0] word);
      @(negedge clk);
      for (int i = 0; i < 2 * FRAME && o_busy; i++) @(negedge clk);
      check("tx_ready", o_busy, 1'b0);
      enable = 1'b1;
      i_data = word;
      @(posedge clk);
      #1;
      enable = 1'b0;
      i_data = ~word;
   endtask

   task automatic drive_frame(input logic [W-1:0] word, input bit stop);
      logic [W+1:0] frame;
      frame = {stop, word, 1'b0};
      for (int b = 0; b < W + 2; b++) begin
         @(posedge clk);
         #1;
         if (b == 0) push_exp(stop, word, cyc);
         ext_line = frame[b];
         repeat (CPB - 1) @(posedge clk);
      end
      @(posedge clk);
      #1 ext_line = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * FRAME && q.size() > 0; i++) @(negedge clk);
      check("rx_drain", q.size(), 0);
   endtask

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ directed tests
   initial begin
      int           base_v, base_e, vld_at, busy_cnt, err_seen;
      logic [9:0]   seen;

      // Reset for two cycles, then 200 quiet cycles.
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      run_cmp = 1'b1;
      check("rst_serial_out", serial_out, 1'b1);
      check("rst_busy", o_busy, 1'b0);
      check("rst_rx_data", received_data, 8'h00);
      check("rst_valid", data_is_valid, 1'b0);
      check("rst_error", rx_error, 1'b0);
      repeat (200) @(posedge clk);
      check("idle_valid_count", obs_valid.size(), 0);
      check("idle_error_count", obs_err, 0);

      // Single loopback frame 8'hA5.
      send(8'hA5);
      vld_at = -1; busy_cnt = 0; err_seen = 0; seen = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (o_busy) busy_cnt++;
         if (i < FRAME && (i % CPB) == CPB / 2) seen[i / CPB] = serial_out;
         if (data_is_valid) vld_at = i;
         if (rx_error) err_seen++;
      end
      check("a5_line_bits", seen, 10'b11_0100_1010);
      check("a5_busy_cycles", busy_cnt, 160);
      check("a5_valid_in_window", (vld_at >= 152) && (vld_at <= 156), 1'b1);
      check("a5_rx_data", received_data, 8'hA5);
      check("a5_no_error", err_seen, 0);

      // Back-to-back frames with no idle gap.
      base_v = obs_valid.size();
      send(8'h00);
      send(8'hFF);
      send(8'h3C);
      drain();
      check("b2b_count", obs_valid.size() - base_v, 3);
      if (obs_valid.size() - base_v == 3) begin
         check("b2b_word0", obs_valid[base_v],     8'h00);
         check("b2b_word1", obs_valid[base_v + 1], 8'hFF);
         check("b2b_word2", obs_valid[base_v + 2], 8'h3C);
      end
      check("b2b_no_error", obs_err, 0);

      // Enable held high and i_data churning while busy.
      send(8'h96);
      enable = 1'b1;
      for (int i = 0; i < 150; i++) begin
         i_data = W'($urandom);
         @(posedge clk);
         #1;
      end
      enable = 1'b0;
      drain();
      check("held_rx_data", received_data, 8'h96);

      // Framing error from an external driver, then a good frame.
      repeat (20) @(posedge clk);
      #1 ext_mode = 1'b1;
      base_v = obs_valid.size();
      base_e = obs_err;
      drive_frame(8'h55, 1'b0);
      drain();
      check("ferr_error_pulses", obs_err - base_e, 1);
      check("ferr_no_valid", obs_valid.size() - base_v, 0);
      check("ferr_rx_data_kept", received_data, 8'h96);
      repeat (20) @(posedge clk);
      drive_frame(8'h12, 1'b1);
      drain();
      check("after_ferr_rx_data", received_data, 8'h12);
      check("after_ferr_valid", obs_valid.size() - base_v, 1);

      // Three-cycle glitch on the line.
      base_v = obs_valid.size();
      base_e = obs_err;
      @(posedge clk);
      #1 ext_line = 1'b0;
      repeat (3) @(posedge clk);
      #1 ext_line = 1'b1;
      repeat (60) @(posedge clk);
      check("glitch_no_valid", obs_valid.size() - base_v, 0);
      check("glitch_no_error", obs_err - base_e, 0);

      // Reset at cycle 50 of a loopback frame.
      #1 ext_mode = 1'b0;
      send(8'hC3);
      base_v = obs_valid.size();
      base_e = obs_err;
      repeat (49) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_serial_out", serial_out, 1'b1);
      check("midrst_busy", o_busy, 1'b0);
      reset = 1'b0;
      repeat (200) @(posedge clk);
      check("midrst_no_valid", obs_valid.size() - base_v, 0);
      check("midrst_no_error", obs_err - base_e, 0);
      check("midrst_rx_data", received_data, 8'h00);

      check("final_queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
